// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational ROM and
// fills the IF/ID register. Handles stall, branch redirect, trap redirect and
// fetch faults (misaligned or out-of-range PC). A faulting fetch parks the
// stage in WAIT_TRAP until the CSR unit steers it away with a trap.
module if_stage #(
  parameter int                 ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter int                 IM_DEPTH  = 128,
  parameter logic [31:0]        NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              trap_valid,
  input  logic [ADDR_W-1:0] trap_pc,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [31:0]       im_rd,
  output logic [31:0]       ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic [ADDR_W-1:0] ifid_pc_plus4,
  output logic              ifid_valid,
  output logic              ifid_fault,
  output logic              fetch_busy_fault
);

  // One past the last valid ROM byte address; one extra bit so it never wraps.
  localparam logic [ADDR_W:0]   IM_BYTES = (ADDR_W+1)'(4 * IM_DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);

  typedef enum logic {
    RUN       = 1'b0,
    WAIT_TRAP = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] ifpc_q, ifpc_d;
  logic [ADDR_W-1:0] ifpc4_q, ifpc4_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;

  logic [ADDR_W-1:0] pc_plus4;
  logic              fault_cond;

  assign pc_plus4   = pc_q + PC_STEP;
  assign fault_cond = (pc_q[1:0] != 2'b00) || ({1'b0, pc_q} >= IM_BYTES);

  // Next-state selection in priority order: trap, redirect, stall, then issue.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    ifpc4_d = ifpc4_q;
    valid_d = valid_q;
    fault_d = fault_q;

    if (trap_valid) begin
      pc_d    = trap_pc;
      instr_d = NOP_INSTR;
      ifpc_d  = pc_q;
      ifpc4_d = pc_plus4;
      valid_d = 1'b0;
      fault_d = 1'b0;
      state_d = RUN;
    end else if (redirect_valid && (state_q == RUN)) begin
      pc_d    = redirect_pc;
      instr_d = NOP_INSTR;
      ifpc_d  = pc_q;
      ifpc4_d = pc_plus4;
      valid_d = 1'b0;
      fault_d = 1'b0;
    end else if (stall) begin
      // Everything holds.
    end else if (state_q == WAIT_TRAP) begin
      instr_d = NOP_INSTR;
      ifpc_d  = pc_q;
      ifpc4_d = pc_plus4;
      valid_d = 1'b0;
      fault_d = 1'b0;
    end else if (fault_cond) begin
      instr_d = NOP_INSTR;
      ifpc_d  = pc_q;
      ifpc4_d = pc_plus4;
      valid_d = 1'b1;
      fault_d = 1'b1;
      state_d = WAIT_TRAP;
    end else begin
      pc_d    = pc_plus4;
      instr_d = im_rd;
      ifpc_d  = pc_q;
      ifpc4_d = pc_plus4;
      valid_d = 1'b1;
      fault_d = 1'b0;
    end
  end

  // State, PC and IF/ID register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      ifpc_q  <= '0;
      ifpc4_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      ifpc4_q <= ifpc4_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign im_addr          = pc_q;
  assign ifid_instr       = instr_q;
  assign ifid_pc          = ifpc_q;
  assign ifid_pc_plus4    = ifpc4_q;
  assign ifid_valid       = valid_q;
  assign ifid_fault       = fault_q;
  assign fetch_busy_fault = (state_q == WAIT_TRAP);

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed stimulus, a behavioural fetch model
// checked every cycle, and literal expectations at key points.
module tb_if_stage;

  localparam int          IM_DEPTH = 128;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirectValid;
  logic [15:0] redirectPc;
  logic        trapValid;
  logic [15:0] trapPc;
  logic [15:0] imAddr;
  logic [31:0] imRd;
  logic [31:0] ifidInstr;
  logic [15:0] ifidPc;
  logic [15:0] ifidPcPlus4;
  logic        ifidValid;
  logic        ifidFault;
  logic        fetchBusyFault;

  logic [31:0] rom [0:IM_DEPTH-1];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: what the IF/ID register must hold.
  logic [15:0] mPc;
  logic        mWaiting;
  logic [31:0] mInstr;
  logic [15:0] mIfPc;
  logic [15:0] mIfPc4;
  logic        mValid;
  logic        mFault;

  if_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall            (stall),
    .redirect_valid   (redirectValid),
    .redirect_pc      (redirectPc),
    .trap_valid       (trapValid),
    .trap_pc          (trapPc),
    .im_addr          (imAddr),
    .im_rd            (imRd),
    .ifid_instr       (ifidInstr),
    .ifid_pc          (ifidPc),
    .ifid_pc_plus4    (ifidPcPlus4),
    .ifid_valid       (ifidValid),
    .ifid_fault       (ifidFault),
    .fetch_busy_fault (fetchBusyFault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ROM; unmapped addresses return a poison word.
  assign imRd = (int'(imAddr) < 4 * IM_DEPTH) ? rom[imAddr[8:2]] : 32'hDEAD_BEEF;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pcIsBad(input logic [15:0] pc);
    return ((int'(pc) % 4) != 0) || (int'(pc) >= 4 * IM_DEPTH);
  endfunction

  // Model: each edge, decide what the fetch stage must do from the rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPc <= 16'h0000; mWaiting <= 1'b0;
      mInstr <= NOP; mIfPc <= 16'h0000; mIfPc4 <= 16'h0000;
      mValid <= 1'b0; mFault <= 1'b0;
    end else if (trapValid || (redirectValid && !mWaiting)) begin
      mPc <= trapValid ? trapPc : redirectPc;
      if (trapValid) mWaiting <= 1'b0;
      mInstr <= NOP; mIfPc <= mPc; mIfPc4 <= mPc + 16'd4;
      mValid <= 1'b0; mFault <= 1'b0;
    end else if (stall) begin
      mPc <= mPc;
    end else if (mWaiting) begin
      mInstr <= NOP; mIfPc <= mPc; mIfPc4 <= mPc + 16'd4;
      mValid <= 1'b0; mFault <= 1'b0;
    end else if (pcIsBad(mPc)) begin
      mWaiting <= 1'b1;
      mInstr <= NOP; mIfPc <= mPc; mIfPc4 <= mPc + 16'd4;
      mValid <= 1'b1; mFault <= 1'b1;
    end else begin
      mInstr <= rom[int'(mPc) / 4]; mIfPc <= mPc; mIfPc4 <= mPc + 16'd4;
      mValid <= 1'b1; mFault <= 1'b0;
      mPc <= mPc + 16'd4;
    end
  end

  // Compare every output against the model midway between rising edges.
  always @(negedge clk) begin
    checkOutput("im_addr",          {16'h0, imAddr},         {16'h0, mPc});
    checkOutput("ifid_instr",       ifidInstr,               mInstr);
    checkOutput("ifid_pc",          {16'h0, ifidPc},         {16'h0, mIfPc});
    checkOutput("ifid_pc_plus4",    {16'h0, ifidPcPlus4},    {16'h0, mIfPc4});
    checkOutput("ifid_valid",       {31'h0, ifidValid},      {31'h0, mValid});
    checkOutput("ifid_fault",       {31'h0, ifidFault},      {31'h0, mFault});
    checkOutput("fetch_busy_fault", {31'h0, fetchBusyFault}, {31'h0, mWaiting});
  end

  task automatic applyStimulus(input logic st, input logic rv, input logic [15:0] rp,
                               input logic tv, input logic [15:0] tp);
    stall = st; redirectValid = rv; redirectPc = rp; trapValid = tv; trapPc = tp;
    @(negedge clk);
  endtask

  task automatic checkIfid(input string tag, input logic [31:0] instr, input logic [15:0] pc,
                           input logic v, input logic f);
    checkOutput({tag, ".instr"}, ifidInstr, instr);
    checkOutput({tag, ".pc"},    {16'h0, ifidPc}, {16'h0, pc});
    checkOutput({tag, ".valid"}, {31'h0, ifidValid}, {31'h0, v});
    checkOutput({tag, ".fault"}, {31'h0, ifidFault}, {31'h0, f});
  endtask

  initial begin
    for (int i = 0; i < IM_DEPTH; i++) rom[i] = {16'hA500, 16'(i)};
    rom[0]   = 32'h01c2_8293;
    rom[1]   = 32'h0000_d073;
    rom[2]   = 32'h0052_9073;
    rom[4]   = 32'h0660_0513;
    rom[7]   = 32'h0410_12f3;
    rom[127] = 32'h7F00_0093;

    rst_n = 1'b0; stall = 1'b0; redirectValid = 1'b0; redirectPc = '0;
    trapValid = 1'b0; trapPc = '0;
    repeat (2) @(negedge clk);
    checkIfid("reset", NOP, 16'h0000, 1'b0, 1'b0);
    checkOutput("reset.im_addr", {16'h0, imAddr}, 32'h0);
    rst_n = 1'b1;

    // Sequential fetch from reset.
    applyStimulus(0, 0, 0, 0, 0);
    checkIfid("edge1", 32'h01c2_8293, 16'h0000, 1'b1, 1'b0);
    applyStimulus(0, 0, 0, 0, 0);
    checkIfid("edge2", 32'h0000_d073, 16'h0004, 1'b1, 1'b0);

    // Stall three edges at pc=8, then resume.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      checkIfid("stall", 32'h0000_d073, 16'h0004, 1'b1, 1'b0);
      checkOutput("stall.im_addr", {16'h0, imAddr}, 32'h8);
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkIfid("edge3", 32'h0052_9073, 16'h0008, 1'b1, 1'b0);
    checkOutput("edge3.pc_plus4", {16'h0, ifidPcPlus4}, 32'hC);

    // Redirect overrides stall.
    applyStimulus(1, 1, 16'h001C, 0, 0);
    checkOutput("redir.valid", {31'h0, ifidValid}, 32'h0);
    checkOutput("redir.im_addr", {16'h0, imAddr}, 32'h1C);
    applyStimulus(0, 0, 0, 0, 0);
    checkIfid("redir.target", 32'h0410_12f3, 16'h001C, 1'b1, 1'b0);

    // Misaligned redirect target faults one edge later and parks.
    applyStimulus(0, 1, 16'h0006, 0, 0);
    checkOutput("mis.bubble", {31'h0, ifidValid}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0);
    checkIfid("mis.fault", NOP, 16'h0006, 1'b1, 1'b1);
    checkOutput("mis.busy", {31'h0, fetchBusyFault}, 32'h1);
    applyStimulus(0, 1, 16'h0040, 0, 0);
    checkOutput("wait.ignore_redir", {16'h0, imAddr}, 32'h6);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    // Trap beats a simultaneous redirect and leaves WAIT_TRAP.
    applyStimulus(0, 1, 16'h0020, 1, 16'h0010);
    checkOutput("trap.im_addr", {16'h0, imAddr}, 32'h10);
    checkOutput("trap.busy", {31'h0, fetchBusyFault}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0);
    checkIfid("trap.target", 32'h0660_0513, 16'h0010, 1'b1, 1'b0);

    // Last ROM word, then out-of-range fault; trap also overrides stall.
    applyStimulus(1, 0, 0, 1, 16'h01FC);
    applyStimulus(0, 0, 0, 0, 0);
    checkIfid("last", 32'h7F00_0093, 16'h01FC, 1'b1, 1'b0);
    checkOutput("last.pc_plus4", {16'h0, ifidPcPlus4}, 32'h200);
    applyStimulus(0, 0, 0, 0, 0);
    checkIfid("range.fault", NOP, 16'h0200, 1'b1, 1'b1);

    // pc_plus4 wraps at the top of the address space.
    applyStimulus(0, 0, 0, 1, 16'hFFFC);
    applyStimulus(0, 0, 0, 0, 0);
    checkIfid("wrap.fault", NOP, 16'hFFFC, 1'b1, 1'b1);
    checkOutput("wrap.pc_plus4", {16'h0, ifidPcPlus4}, 32'h0);

    // Back to normal code, then asynchronous reset during a stall.
    applyStimulus(0, 0, 0, 1, 16'h0000);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checkIfid("async", NOP, 16'h0000, 1'b0, 1'b0);
    checkOutput("async.im_addr", {16'h0, imAddr}, 32'h0);
    checkOutput("async.pc_plus4", {16'h0, ifidPcPlus4}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    stall = 1'b0;
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    checkIfid("post_reset", 32'h01c2_8293, 16'h0000, 1'b1, 1'b0);
    applyStimulus(0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
